pipe_ctrl: RTL and testbench

//  Central pipeline controller for the 5-stage core. Drives the stall vector and jump-flush consumed by
//  pc_reg, if_id, id_exe, exe_mem and mem_wb. Detects load-use hazards, sequences multi-cycle EX ops and

---
 rtl/pipe_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central hazard/stall controller for the 5-stage core.
// Produces the per-stage stall vector and the jump flush/redirect, tracks
// multi-cycle EX ops and MEM bus waits, and flags waits that never finish.
// Optional feature macro: PIPE_CTRL_PERF_EN (adds stall/flush/load-use counters).
module pipe_ctrl #(
  parameter int ADDR_WIDTH  = 32,
  parameter int RADDR_WIDTH = 5,
  parameter int WAIT_LIMIT  = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [RADDR_WIDTH-1:0] id_rs1_raddr_i,
  input  logic                   id_rs1_re_i,
  input  logic [RADDR_WIDTH-1:0] id_rs2_raddr_i,
  input  logic                   id_rs2_re_i,
  input  logic                   ex_inst_is_load_i,
  input  logic [RADDR_WIDTH-1:0] ex_rd_i,
  input  logic                   ex_jump_i,
  input  logic [ADDR_WIDTH-1:0]  ex_jump_addr_i,
  input  logic                   ex_mc_start_i,
  input  logic                   mc_done_i,
  input  logic                   mem_req_i,
  input  logic                   mem_ack_i,
  output logic [5:0]             stall_o,
  output logic                   flush_jump_o,
  output logic [ADDR_WIDTH-1:0]  jump_addr_o,
  output logic                   timeout_err_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]            perf_stall_cnt_o,
  output logic [31:0]            perf_flush_cnt_o,
  output logic [31:0]            perf_lu_cnt_o
`endif
);

  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_MC   = 6'b001111;
  localparam logic [5:0] STALL_LU   = 6'b000111;
  localparam logic [7:0] WAIT_LIM_C = 8'(WAIT_LIMIT);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MC_WAIT  = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t     state_reg;
  logic [7:0] wait_cnt_reg;
  logic       timeout_err_reg;

  logic       mem_wait;
  logic       mc_wait;
  logic       rs1_hit;
  logic       rs2_hit;
  logic       load_use;
  logic       flush_jump;
  logic       lu_stall;
  logic       wait_release;
  logic [7:0] wait_cnt_inc;

  // Hazard classification from current state and this cycle's pipeline inputs
  always_comb begin
    mem_wait     = ((state_reg == MEM_WAIT) && !mem_ack_i) ||
                   ((state_reg == RUN) && mem_req_i && !mem_ack_i);
    mc_wait      = ((state_reg == MC_WAIT) && !mc_done_i) ||
                   ((state_reg == RUN) && ex_mc_start_i);
    rs1_hit      = id_rs1_re_i && (id_rs1_raddr_i == ex_rd_i);
    rs2_hit      = id_rs2_re_i && (id_rs2_raddr_i == ex_rd_i);
    // x0 is never a real destination, so it cannot create a hazard
    load_use     = ex_inst_is_load_i && (ex_rd_i != '0) && (rs1_hit || rs2_hit);
    // A jump resolved while EX is frozen is not final yet; hold it off
    flush_jump   = ex_jump_i && !mem_wait && !mc_wait;
    // The flushed ID instruction is discarded, so its hazard is moot
    lu_stall     = load_use && !flush_jump && !mem_wait && !mc_wait;
    wait_release = (state_reg == MEM_WAIT) ? mem_ack_i : mc_done_i;
    wait_cnt_inc = wait_cnt_reg + 8'd1;
  end

  // Output drive; everything is forced low while reset is asserted
  always_comb begin
    stall_o      = 6'b000000;
    flush_jump_o = 1'b0;
    jump_addr_o  = '0;
    if (!rst_i) begin
      if (mem_wait)
        stall_o = STALL_MEM;
      else if (mc_wait)
        stall_o = STALL_MC;
      else if (lu_stall)
        stall_o = STALL_LU;
      flush_jump_o = flush_jump;
      if (flush_jump)
        jump_addr_o = ex_jump_addr_i;
    end
  end

  // Wait-state FSM with watchdog; the LIMIT-th consecutive wait cycle without
  // completion raises the sticky error and forces the pipeline back to RUN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg       <= RUN;
      wait_cnt_reg    <= 8'd0;
      timeout_err_reg <= 1'b0;
    end else begin
      case (state_reg)
        RUN: begin
          wait_cnt_reg <= 8'd0;
          if (mem_req_i && !mem_ack_i)
            state_reg <= MEM_WAIT;
          else if (ex_mc_start_i)
            state_reg <= MC_WAIT;
        end
        MC_WAIT, MEM_WAIT: begin
          if (wait_release) begin
            state_reg    <= RUN;
            wait_cnt_reg <= 8'd0;
          end else if (wait_cnt_inc == WAIT_LIM_C) begin
            state_reg       <= RUN;
            wait_cnt_reg    <= 8'd0;
            timeout_err_reg <= 1'b1;
          end else begin
            wait_cnt_reg <= wait_cnt_inc;
          end
        end
        default: begin
          state_reg    <= RUN;
          wait_cnt_reg <= 8'd0;
        end
      endcase
    end
  end

  assign timeout_err_o = timeout_err_reg;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_cnt_reg;
  logic [31:0] perf_flush_cnt_reg;
  logic [31:0] perf_lu_cnt_reg;

  // Free-running event counters, wrapping naturally at 2^32
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_stall_cnt_reg <= 32'd0;
      perf_flush_cnt_reg <= 32'd0;
      perf_lu_cnt_reg    <= 32'd0;
    end else begin
      if (stall_o[0])
        perf_stall_cnt_reg <= perf_stall_cnt_reg + 32'd1;
      if (flush_jump_o)
        perf_flush_cnt_reg <= perf_flush_cnt_reg + 32'd1;
      if (lu_stall)
        perf_lu_cnt_reg <= perf_lu_cnt_reg + 32'd1;
    end
  end

  assign perf_stall_cnt_o = perf_stall_cnt_reg;
  assign perf_flush_cnt_o = perf_flush_cnt_reg;
  assign perf_lu_cnt_o    = perf_lu_cnt_reg;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed scenarios followed by random
// traffic, expected responses produced by a cycle-level reference model.
module tb_pipe_ctrl;
  localparam int LIMIT = 8;

  typedef struct packed {
    logic [4:0]  rs1;
    logic        re1;
    logic [4:0]  rs2;
    logic        re2;
    logic        ld;
    logic [4:0]  rd;
    logic        jmp;
    logic [31:0] jaddr;
    logic        mcs;
    logic        done;
    logic        req;
    logic        ack;
  } in_t;

  typedef struct packed {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] addr;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
  logic        re1 = 0, re2 = 0, ld = 0, jmp = 0, mcs = 0, done = 0, req = 0, ack = 0;
  logic [31:0] jaddr = '0;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] addr;
  logic        err;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] p_stall, p_flush, p_lu;
`endif

  pipe_ctrl #(.ADDR_WIDTH(32), .RADDR_WIDTH(5), .WAIT_LIMIT(LIMIT)) dut (
    .clk_i(clk), .rst_i(rst),
    .id_rs1_raddr_i(rs1), .id_rs1_re_i(re1),
    .id_rs2_raddr_i(rs2), .id_rs2_re_i(re2),
    .ex_inst_is_load_i(ld), .ex_rd_i(rd),
    .ex_jump_i(jmp), .ex_jump_addr_i(jaddr),
    .ex_mc_start_i(mcs), .mc_done_i(done),
    .mem_req_i(req), .mem_ack_i(ack),
    .stall_o(stall), .flush_jump_o(flush), .jump_addr_o(addr), .timeout_err_o(err)
`ifdef PIPE_CTRL_PERF_EN
    , .perf_stall_cnt_o(p_stall), .perf_flush_cnt_o(p_flush), .perf_lu_cnt_o(p_lu)
`endif
  );

  always #5 clk = ~clk;

  int   tests = 0;
  int   fails = 0;
  exp_t sb_q[$];

  // Reference model: mode 0 = running, 1 = waiting on multi-cycle unit, 2 = waiting on bus
  int m_mode = 0;
  int m_waited = 0;
  bit m_err = 0;
  int m_stall_n = 0, m_flush_n = 0, m_lu_n = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    tests++;
    if (act !== req_v) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req_v, $time);
    end
  endtask

  task automatic apply(input in_t s);
    rs1 = s.rs1; re1 = s.re1; rs2 = s.rs2; re2 = s.re2; ld = s.ld; rd = s.rd;
    jmp = s.jmp; jaddr = s.jaddr; mcs = s.mcs; done = s.done; req = s.req; ack = s.ack;
  endtask

  task automatic model_step(input in_t s, output exp_t e);
    bit ex_frozen_mem, ex_frozen_mc, hazard, fl, finished;
    ex_frozen_mem = (m_mode == 2 || (m_mode == 0 && s.req)) && !s.ack;
    ex_frozen_mc  = (m_mode == 1 && !s.done) || (m_mode == 0 && s.mcs);
    hazard = s.ld && (s.rd != 0) &&
             ((s.re1 && s.rs1 == s.rd) || (s.re2 && s.rs2 == s.rd));
    fl = s.jmp && !ex_frozen_mem && !ex_frozen_mc;
    e.err   = m_err;
    e.flush = fl;
    e.addr  = fl ? s.jaddr : 32'd0;
    if (ex_frozen_mem)      e.stall = 6'b011111;
    else if (ex_frozen_mc)  e.stall = 6'b001111;
    else if (hazard && !fl) e.stall = 6'b000111;
    else                    e.stall = 6'b000000;
    m_stall_n += int'(e.stall[0]);
    m_flush_n += int'(fl);
    m_lu_n    += int'(e.stall == 6'b000111);
    // advance the model to the next cycle
    if (m_mode == 0) begin
      m_waited = 0;
      if (s.req && !s.ack) m_mode = 2;
      else if (s.mcs)      m_mode = 1;
    end else begin
      finished = (m_mode == 2) ? s.ack : s.done;
      if (finished) begin
        m_mode = 0; m_waited = 0;
      end else begin
        m_waited++;
        if (m_waited == LIMIT) begin
          m_err = 1; m_mode = 0; m_waited = 0;
        end
      end
    end
  endtask

  task automatic cyc(input in_t s);
    exp_t e;
    @(posedge clk);
    #1;
    apply(s);
    model_step(s, e);
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n);
    in_t z;
    z = '0;
    for (int i = 0; i < n; i++) cyc(z);
  endtask

  function automatic in_t rnd(input int ack_bias);
    in_t s;
    s.rs1   = 5'($urandom_range(0, 3));
    s.re1   = 1'($urandom_range(0, 1));
    s.rs2   = 5'($urandom_range(0, 3));
    s.re2   = 1'($urandom_range(0, 1));
    s.ld    = ($urandom_range(0, 2) == 0);
    s.rd    = 5'($urandom_range(0, 3));
    s.jmp   = ($urandom_range(0, 3) == 0);
    s.jaddr = $urandom;
    s.mcs   = ($urandom_range(0, 5) == 0);
    s.done  = ($urandom_range(0, 4) == 0);
    s.req   = ($urandom_range(0, 3) == 0);
    s.ack   = ($urandom_range(0, ack_bias) == 0);
    return s;
  endfunction

  // Monitor: every cycle with a pending expectation is compared mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (!rst && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("stall", 32'(stall), 32'(e.stall));
      chk("flush", 32'(flush), 32'(e.flush));
      chk("jump_addr", addr, e.addr);
      chk("timeout_err", 32'(err), 32'(e.err));
      $display("[TB] cyc t=%0t stall=%06b flush=%0b addr=%08h err=%0b", $time, stall, flush, addr, err);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    in_t s;
    // outputs held low under reset even with hazard/jump/bus inputs active
    s = '0; s.ld = 1; s.rd = 5'd3; s.rs1 = 5'd3; s.re1 = 1; s.jmp = 1; s.jaddr = 32'hdead_beef; s.req = 1;
    apply(s);
    #12;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_addr", addr, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    s = '0;
    apply(s);
    @(negedge clk); #1 rst = 0;

    // load-use on rs1, then clear
    s = '0; s.ld = 1; s.rd = 5'd5; s.rs1 = 5'd5; s.re1 = 1; cyc(s);
    idle(1);
    // load into x0 is not a hazard
    s = '0; s.ld = 1; s.rd = 5'd0; s.rs1 = 5'd0; s.re1 = 1; cyc(s);
    // load-use on rs2, with rs1 mismatching
    s = '0; s.ld = 1; s.rd = 5'd7; s.rs1 = 5'd1; s.re1 = 1; s.rs2 = 5'd7; s.re2 = 1; cyc(s);
    // load-use suppressed by a jump flush
    s.jmp = 1; s.jaddr = 32'h0000_4000; cyc(s);
    // multi-cycle op: start, 3 waits, done
    s = '0; s.mcs = 1; cyc(s);
    idle(3);
    s = '0; s.done = 1; cyc(s);
    idle(1);
    // bus wait with pending jump, ack on the 4th cycle
    s = '0; s.req = 1; s.jmp = 1; s.jaddr = 32'h1234_5678;
    for (int i = 0; i < 3; i++) cyc(s);
    s.ack = 1; cyc(s);
    idle(1);
    // bus never acknowledges: watchdog expires
    s = '0; s.req = 1;
    for (int i = 0; i < LIMIT + 1; i++) cyc(s);
    idle(2);

    // random traffic, short and long bus latencies
    for (int i = 0; i < 300; i++) cyc(rnd(2));
    for (int i = 0; i < 300; i++) cyc(rnd(14));

    // asynchronous reset in the middle of a multi-cycle wait
    s = '0; s.mcs = 1; cyc(s);
    idle(2);
    @(negedge clk); #1;
    rst = 1;
    #1;
    chk("async_rst_stall", 32'(stall), 32'd0);
    chk("async_rst_err", 32'(err), 32'd0);
`ifdef PIPE_CTRL_PERF_EN
    chk("async_rst_perf_stall", p_stall, 32'd0);
    chk("async_rst_perf_flush", p_flush, 32'd0);
    chk("async_rst_perf_lu", p_lu, 32'd0);
`endif
    s = '0; apply(s);
    m_mode = 0; m_waited = 0; m_err = 0;
    m_stall_n = 0; m_flush_n = 0; m_lu_n = 0;
    @(negedge clk); #1 rst = 0;

    for (int i = 0; i < 200; i++) cyc(rnd(8));

    @(negedge clk); #1;
    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    @(posedge clk); #1;
`ifdef PIPE_CTRL_PERF_EN
    chk("perf_stall", p_stall, 32'(m_stall_n));
    chk("perf_flush", p_flush, 32'(m_flush_n));
    chk("perf_lu", p_lu, 32'(m_lu_n));
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
